// File: rtl/complex_mult_axis_pkg.sv
// Shared definitions for the complex multiplier datapath.
//   CMULT_MIN_PIPE     : fewest pipeline stages the multiplier supports
//   round_mode_t       : encoding of the per-sample round_en bit
//   cmult_delay_stages : number of pure delay stages behind stage 4
package complex_mult_axis_pkg;

   localparam int CMULT_MIN_PIPE = 4;

   typedef enum logic {
      RND_TRUNC   = 1'b0,
      RND_HALF_UP = 1'b1
   } round_mode_t;

   function automatic int cmult_delay_stages(input int pipe_num);
      return (pipe_num > CMULT_MIN_PIPE) ? (pipe_num - CMULT_MIN_PIPE) : 0;
   endfunction

endpackage

// File: rtl/complex_mult_axis_if.sv
// Stream bundle for the complex multiplier: input sample channel (s_*),
// operands and per-sample controls, and the result channel (m_*).
//   slave  : the multiplier's view (consumes s_*, produces m_*)
//   master : the driver/sink view (produces s_*, consumes m_*)
interface complex_mult_axis_if #(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int OUT_W = 16
);
   logic                    s_valid;
   logic                    s_ready;
   logic                    s_last;
   logic signed [A_W-1:0]   a_re;
   logic signed [A_W-1:0]   a_im;
   logic signed [B_W-1:0]   b_re;
   logic signed [B_W-1:0]   b_im;
   logic                    conj_b;
   logic                    round_en;
   logic                    m_valid;
   logic                    m_ready;
   logic                    m_last;
   logic signed [OUT_W-1:0] z_re;
   logic signed [OUT_W-1:0] z_im;
   logic                    z_ovf;

   modport slave (
      input  s_valid, s_last, a_re, a_im, b_re, b_im, conj_b, round_en, m_ready,
      output s_ready, m_valid, m_last, z_re, z_im, z_ovf
   );

   modport master (
      output s_valid, s_last, a_re, a_im, b_re, b_im, conj_b, round_en, m_ready,
      input  s_ready, m_valid, m_last, z_re, z_im, z_ovf
   );

endinterface

// File: rtl/complex_mult_axis_round_sat.sv
// cplx_round_sat: combinational round / arithmetic-shift / saturate for one
// component of the full-precision complex product.
//   val_i      : P_W-bit signed full-precision value
//   round_en_i : 1 = add half an LSB before shifting, 0 = truncate (floor)
//   val_o      : OUT_W-bit signed saturated result
//   ovf_o      : result was clipped to the output range
module cplx_round_sat #(
   parameter int P_W        = 33,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 15
) (
   input  logic signed [P_W-1:0]   val_i,
   input  logic                    round_en_i,
   output logic signed [OUT_W-1:0] val_o,
   output logic                    ovf_o
);

   // One guard bit so the rounding bias can never wrap the maximum input.
   localparam int W = P_W + 1;

   localparam logic signed [W-1:0] SAT_MAX =
      $signed({{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [W-1:0] SAT_MIN =
      $signed({{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

   logic signed [W-1:0] ext;
   logic signed [W-1:0] biased;
   logic signed [W-1:0] shifted;

   assign ext = W'(val_i);

   generate
      if (FRAC_SHIFT > 0) begin : g_round
         localparam logic [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
         assign biased = round_en_i ? (ext + $signed(HALF)) : ext;
      end else begin : g_no_round
         assign biased = ext;
      end
   endgenerate

   assign shifted = biased >>> FRAC_SHIFT;

   always_comb begin
      val_o = shifted[OUT_W-1:0];
      ovf_o = 1'b0;
      if (shifted > SAT_MAX) begin
         val_o = SAT_MAX[OUT_W-1:0];
         ovf_o = 1'b1;
      end else if (shifted < SAT_MIN) begin
         val_o = SAT_MIN[OUT_W-1:0];
         ovf_o = 1'b1;
      end
   end

endmodule

// File: rtl/complex_mult_axis.sv
// Pipelined complex multiplier z = a * b (or a * conj(b)) with stream
// handshake, full backpressure, per-sample rounding and output saturation.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, flushes every stage
//   bus : complex_mult_axis_if.slave (s_* input channel, m_* result channel)
// Stages: 1 operand register, 2 products, 3 sum/difference,
// 4 round/saturate, 5..PIPE_NUM delay. The whole pipe stalls together when
// the output holds an unaccepted result; bubbles are not compacted.
// PIPE_NUM below CMULT_MIN_PIPE behaves as CMULT_MIN_PIPE.
module complex_mult_axis
   import complex_mult_axis_pkg::*;
#(
   parameter int A_W        = 16,
   parameter int B_W        = 16,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 15,
   parameter int PIPE_NUM   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   complex_mult_axis_if.slave   bus
);

   localparam int PROD_W = A_W + B_W;
   localparam int P_W    = PROD_W + 1;
   localparam int DLY    = cmult_delay_stages(PIPE_NUM);

   logic adv;
   logic in_xfer;

   assign adv         = ~bus.m_valid | bus.m_ready;
   assign bus.s_ready = adv;
   assign in_xfer     = bus.s_valid & adv;

   // stage 1
   logic                  v1_q, conj1_q, rnd1_q, last1_q;
   logic signed [A_W-1:0] ar1_q, ai1_q;
   logic signed [B_W-1:0] br1_q, bi1_q;

   // stage 2
   logic                     v2_q, rnd2_q, last2_q;
   logic signed [PROD_W-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [PROD_W-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
   logic signed [B_W:0]      bi_ext, bi_eff_d;

   // stage 3
   logic                  v3_q, rnd3_q, last3_q;
   logic signed [P_W-1:0] re3_q, im3_q;

   // stage 4 and delay chain; index DLY drives the outputs
   logic signed [OUT_W-1:0] re4_d, im4_d;
   logic                    ovf_re_d, ovf_im_d;
   logic                    ov_q    [DLY+1];
   logic                    olast_q [DLY+1];
   logic                    oovf_q  [DLY+1];
   logic signed [OUT_W-1:0] ore_q   [DLY+1];
   logic signed [OUT_W-1:0] oim_q   [DLY+1];

   // Negating b_im needs one extra bit for the most-negative code; the
   // product width still holds the result since |a| * |b| <= 2^(PROD_W-2).
   assign bi_ext   = (B_W+1)'(bi1_q);
   assign bi_eff_d = conj1_q ? -bi_ext : bi_ext;

   assign p_rr_d = PROD_W'(ar1_q) * PROD_W'(br1_q);
   assign p_ii_d = PROD_W'(ai1_q) * PROD_W'(bi_eff_d);
   assign p_ri_d = PROD_W'(ar1_q) * PROD_W'(bi_eff_d);
   assign p_ir_d = PROD_W'(ai1_q) * PROD_W'(br1_q);

   cplx_round_sat #(.P_W(P_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_re (
      .val_i      (re3_q),
      .round_en_i (rnd3_q),
      .val_o      (re4_d),
      .ovf_o      (ovf_re_d)
   );

   cplx_round_sat #(.P_W(P_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_im (
      .val_i      (im3_q),
      .round_en_i (rnd3_q),
      .val_o      (im4_d),
      .ovf_o      (ovf_im_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         conj1_q <= 1'b0;
         rnd1_q  <= 1'b0;
         last1_q <= 1'b0;
         ar1_q   <= '0;
         ai1_q   <= '0;
         br1_q   <= '0;
         bi1_q   <= '0;
         v2_q    <= 1'b0;
         rnd2_q  <= 1'b0;
         last2_q <= 1'b0;
         p_rr_q  <= '0;
         p_ii_q  <= '0;
         p_ri_q  <= '0;
         p_ir_q  <= '0;
         v3_q    <= 1'b0;
         rnd3_q  <= 1'b0;
         last3_q <= 1'b0;
         re3_q   <= '0;
         im3_q   <= '0;
         for (int i = 0; i <= DLY; i++) begin
            ov_q[i]    <= 1'b0;
            olast_q[i] <= 1'b0;
            oovf_q[i]  <= 1'b0;
            ore_q[i]   <= '0;
            oim_q[i]   <= '0;
         end
      end else if (adv) begin
         v1_q    <= in_xfer;
         conj1_q <= bus.conj_b;
         rnd1_q  <= bus.round_en;
         last1_q <= bus.s_last;
         ar1_q   <= bus.a_re;
         ai1_q   <= bus.a_im;
         br1_q   <= bus.b_re;
         bi1_q   <= bus.b_im;

         v2_q    <= v1_q;
         rnd2_q  <= rnd1_q;
         last2_q <= last1_q;
         p_rr_q  <= p_rr_d;
         p_ii_q  <= p_ii_d;
         p_ri_q  <= p_ri_d;
         p_ir_q  <= p_ir_d;

         v3_q    <= v2_q;
         rnd3_q  <= rnd2_q;
         last3_q <= last2_q;
         re3_q   <= P_W'(p_rr_q) - P_W'(p_ii_q);
         im3_q   <= P_W'(p_ri_q) + P_W'(p_ir_q);

         ov_q[0]    <= v3_q;
         olast_q[0] <= last3_q;
         oovf_q[0]  <= ovf_re_d | ovf_im_d;
         ore_q[0]   <= re4_d;
         oim_q[0]   <= im4_d;
         for (int i = 1; i <= DLY; i++) begin
            ov_q[i]    <= ov_q[i-1];
            olast_q[i] <= olast_q[i-1];
            oovf_q[i]  <= oovf_q[i-1];
            ore_q[i]   <= ore_q[i-1];
            oim_q[i]   <= oim_q[i-1];
         end
      end
   end

   assign bus.m_valid = ov_q[DLY];
   assign bus.m_last  = olast_q[DLY];
   assign bus.z_ovf   = oovf_q[DLY];
   assign bus.z_re    = ore_q[DLY];
   assign bus.z_im    = oim_q[DLY];

endmodule

// File: tb/tb_complex_mult_axis.sv
module tb_complex_mult_axis;
   import complex_mult_axis_pkg::*;

   localparam int A_W        = 16;
   localparam int B_W        = 16;
   localparam int OUT_W      = 16;
   localparam int FRAC_SHIFT = 15;
   localparam int PIPE_NUM   = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   complex_mult_axis_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) bus ();

   complex_mult_axis #(
      .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W),
      .FRAC_SHIFT(FRAC_SHIFT), .PIPE_NUM(PIPE_NUM)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      longint re;
      longint im;
      bit     ovf;
      bit     last;
   } exp_t;

   exp_t   exp_q[$];
   int     n_chk = 0;
   int     n_pass = 0;
   int     cyc = 0;
   int     acc_cyc = 0;
   int     out_cyc = 0;
   int     n_in = 0;
   int     n_out = 0;
   bit     sready_seen = 1'b1;
   longint last_re = 0;
   longint last_im = 0;
   longint last_ovf = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference: exact integer complex product, floor scaling, clip.
   function automatic exp_t model(input longint ar, input longint ai,
                                  input longint br, input longint bi,
                                  input bit conj, input round_mode_t rm,
                                  input bit last);
      exp_t   e;
      longint bi_e, re, im, hi, lo;
      hi   = (longint'(1) << (OUT_W - 1)) - 1;
      lo   = -(longint'(1) << (OUT_W - 1));
      bi_e = conj ? -bi : bi;
      re   = ar * br - ai * bi_e;
      im   = ar * bi_e + ai * br;
      if (rm == RND_HALF_UP) begin
         re = re + (longint'(1) << (FRAC_SHIFT - 1));
         im = im + (longint'(1) << (FRAC_SHIFT - 1));
      end
      re = re >>> FRAC_SHIFT;
      im = im >>> FRAC_SHIFT;
      e.ovf = 1'b0;
      if (re > hi) begin re = hi; e.ovf = 1'b1; end
      if (re < lo) begin re = lo; e.ovf = 1'b1; end
      if (im > hi) begin im = hi; e.ovf = 1'b1; end
      if (im < lo) begin im = lo; e.ovf = 1'b1; end
      e.re   = re;
      e.im   = im;
      e.last = last;
      return e;
   endfunction

   task automatic drive(input bit v, input int ar, input int ai, input int br,
                        input int bi, input bit conj, input round_mode_t rm,
                        input bit last);
      bus.s_valid  = v;
      bus.a_re     = A_W'(ar);
      bus.a_im     = A_W'(ai);
      bus.b_re     = B_W'(br);
      bus.b_im     = B_W'(bi);
      bus.conj_b   = conj;
      bus.round_en = (rm == RND_HALF_UP);
      bus.s_last   = last;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 0, 0, 1'b0, RND_TRUNC, 1'b0);
   endtask

   // One clock: inputs were set after the falling edge; observe mid-cycle,
   // score transfers, then move to the next falling edge.
   task automatic step();
      exp_t e;
      #4;
      sready_seen = bus.s_ready;
      if (bus.m_valid && bus.m_ready) begin
         chk("out_expected", longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("z_re", bus.z_re, e.re);
            chk("z_im", bus.z_im, e.im);
            chk("z_ovf", bus.z_ovf, e.ovf);
            chk("m_last", bus.m_last, e.last);
         end
         last_re  = bus.z_re;
         last_im  = bus.z_im;
         last_ovf = bus.z_ovf;
         out_cyc  = cyc;
         n_out++;
      end
      if (bus.s_valid && bus.s_ready) begin
         exp_q.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im,
                               bus.conj_b, round_mode_t'(bus.round_en), bus.s_last));
         acc_cyc = cyc;
         n_in++;
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input int ar, input int ai, input int br, input int bi,
                       input bit conj, input round_mode_t rm, input bit last);
      int base;
      base = n_in;
      drive(1'b1, ar, ai, br, bi, conj, rm, last);
      for (int k = 0; k < 50; k++) begin
         step();
         if (n_in != base) break;
      end
      chk("accepted", n_in - base, 1);
      idle();
   endtask

   task automatic drain();
      bus.m_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   function automatic int rnd_val();
      case ($urandom_range(0, 7))
         0:       return -32768;
         1:       return 32767;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          vals [10][4];
      int          base_in, base_out, p, phase;
      bit          pat [5];
      bit          pend;
      int          rv [4];
      bit          rc, rl;
      round_mode_t rr;

      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      rst = 1'b1;
      idle();
      bus.m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_last", bus.m_last, 0);
      chk("rst_z_re", bus.z_re, 0);
      chk("rst_z_im", bus.z_im, 0);
      chk("rst_z_ovf", bus.z_ovf, 0);
      chk("rst_s_ready", bus.s_ready, 1);

      // basic scaling and latency
      bus.m_ready = 1'b1;
      send(16384, 0, 16384, 0, 1'b0, RND_TRUNC, 1'b0);
      drain();
      chk("t1_re", last_re, 8192);
      chk("t1_im", last_im, 0);
      chk("t1_ovf", last_ovf, 0);
      chk("t1_latency", out_cyc - acc_cyc, 4);

      // conjugation
      send(1000, 2000, 16384, 16384, 1'b1, RND_TRUNC, 1'b0);
      drain();
      chk("t2c_re", last_re, 1500);
      chk("t2c_im", last_im, 500);
      send(1000, 2000, 16384, 16384, 1'b0, RND_TRUNC, 1'b0);
      drain();
      chk("t2n_re", last_re, -500);
      chk("t2n_im", last_im, 1500);

      // rounding
      send(1, 0, 16384, 0, 1'b0, RND_HALF_UP, 1'b0);
      drain();
      chk("t3_pos_rnd", last_re, 1);
      send(1, 0, 16384, 0, 1'b0, RND_TRUNC, 1'b0);
      drain();
      chk("t3_pos_trunc", last_re, 0);
      send(-1, 0, 16384, 0, 1'b0, RND_HALF_UP, 1'b0);
      drain();
      chk("t3_neg_rnd", last_re, 0);
      send(-1, 0, 16384, 0, 1'b0, RND_TRUNC, 1'b0);
      drain();
      chk("t3_neg_trunc", last_re, -1);

      // saturation
      send(-32768, -32768, -32768, 0, 1'b0, RND_TRUNC, 1'b0);
      drain();
      chk("t4_re", last_re, 32767);
      chk("t4_im", last_im, 32767);
      chk("t4_ovf", last_ovf, 1);
      send(100, -200, 16384, 0, 1'b0, RND_TRUNC, 1'b0);
      drain();
      chk("t4_next_ovf", last_ovf, 0);
      chk("t4_next_re", last_re, 50);

      // backpressure: 10 samples, sink stalled then toggling
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < 4; j++) vals[i][j] = rnd_val();
      bus.m_ready = 1'b0;
      base_in  = n_in;
      base_out = n_out;
      phase = 0;
      p = 0;
      for (int k = 0; k < 300; k++) begin
         if (n_in - base_in < 10)
            drive(1'b1, vals[n_in-base_in][0], vals[n_in-base_in][1],
                  vals[n_in-base_in][2], vals[n_in-base_in][3],
                  1'b0, RND_HALF_UP, (n_in - base_in) == 9);
         else
            idle();
         step();
         if (phase == 0 && !sready_seen) begin
            chk("bp_held_at_stall", n_in - base_in, 4);
            phase = 1;
         end
         if (phase == 1) begin
            bus.m_ready = pat[p % 5];
            p++;
         end
         if (n_out - base_out >= 10) break;
      end
      idle();
      chk("bp_stall_seen", phase, 1);
      chk("bp_out_count", n_out - base_out, 10);
      chk("bp_queue_empty", exp_q.size(), 0);

      // reset with three samples in flight
      bus.m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1000 * (i + 1), 0, 16384, 0, 1'b0, RND_TRUNC, 1'b0);
         step();
      end
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      chk("t6_m_valid", bus.m_valid, 0);
      chk("t6_s_ready", bus.s_ready, 1);
      base_out = n_out;
      repeat (8) step();
      chk("t6_no_ghosts", n_out - base_out, 0);
      send(3000, -3000, 16384, 0, 1'b0, RND_TRUNC, 1'b1);
      drain();
      chk("t6_latency", out_cyc - acc_cyc, 4);
      chk("t6_re", last_re, 1500);

      // randomized traffic against the reference
      pend = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            for (int j = 0; j < 4; j++) rv[j] = rnd_val();
            rc = 1'($urandom_range(0, 1));
            rr = round_mode_t'($urandom_range(0, 1));
            rl = ($urandom_range(0, 4) == 0);
            pend = 1'b1;
         end
         if (pend) drive(1'b1, rv[0], rv[1], rv[2], rv[3], rc, rr, rl);
         else      idle();
         bus.m_ready = ($urandom_range(0, 9) < 7);
         base_in = n_in;
         step();
         if (n_in != base_in) pend = 1'b0;
      end
      idle();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/complex_mult_axis.md
Name: complex_mult_axis

Overview:
- Parametrised pipelined complex multiplier with AXI-Stream-style valid/ready handshake, full backpressure, optional conjugation of operand b, selectable rounding and output saturation.
- Successor to the fixed-width int multiplier. Used in the window-function datapath: data sample × window coefficient, and for FFT twiddle multiplication.
- Outputs a fixed-point-scaled result of width OUT_W plus a per-sample overflow flag.

Parameters:
- A_W, 16, bit width of each signed component (re/im) of operand a
- B_W, 16, bit width of each signed component of operand b
- OUT_W, 16, bit width of each signed output component
- FRAC_SHIFT, 15, arithmetic right shift applied to the full-precision result (range 0 .. A_W+B_W)
- PIPE_NUM, 4, total latency in accepted-transfer cycles; minimum 4, extra stages are delay-only

Ports:
- clk, in, 1, clock; all logic on rising edge
- rst, in, 1, synchronous active-high reset
- s_valid, in, 1, input sample valid
- s_ready, out, 1, block can accept input this cycle
- s_last, in, 1, frame marker carried alongside the data
- a_re / a_im, in, A_W each, signed operand a
- b_re / b_im, in, B_W each, signed operand b
- conj_b, in, 1, sampled with the data; 1 = multiply by conj(b)
- round_en, in, 1, sampled with the data; 1 = round half up, 0 = truncate toward −inf
- m_valid, out, 1, output valid
- m_ready, in, 1, downstream ready
- m_last, out, 1, delayed s_last
- z_re / z_im, out, OUT_W each, signed result
- z_ovf, out, 1, set if either component saturated for this sample

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid bits cleared; m_valid=0, m_last=0, z_re=z_im=0, z_ovf=0; s_ready=1 in the cycle after reset. Any in-flight data is discarded, including data mid-pipeline.
- Pipeline advance: adv = ~m_valid | m_ready. s_ready = adv (combinational, no dependence on s_valid).
- Transfer in: s_valid & s_ready. Transfer out: m_valid & m_ready.
- When adv=0, every stage holds; m_valid and the output data are stable until accepted.
- Bubbles propagate as invalid stages. No compaction of bubbles is required.
- Latency: a sample accepted at edge N appears with m_valid=1 after edge N+PIPE_NUM-1, provided adv stayed 1. Throughput is 1 sample/cycle.
- Stage 1: register the operands, conj_b, round_en and s_last.
- Stage 2: form four products at A_W+B_W bits; when conj_b=1, b_im is negated (the −2^(B_W-1) case is handled by the wider product width).
- Stage 3: re = ar·br − ai·bi, im = ar·bi + ai·br, at full width P = A_W+B_W+1 with no loss.
- Stage 4: if round_en, add 2^(FRAC_SHIFT−1) (skipped when FRAC_SHIFT=0), then arithmetic shift right by FRAC_SHIFT.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - z_ovf = saturation occurred on re OR im.
- Stages 5..PIPE_NUM: pure delay registers, stalled by adv like the others.
- s_last, conj_b and round_en travel with their own sample; changing them between samples affects only the sample they arrive with.
- Simultaneous transfer-out and transfer-in in one cycle is legal and loses nothing.

Decomposition:
- axis_pkg gains:
  - localparam CMULT_MIN_PIPE = 4
  - typedef enum logic {RND_TRUNC, RND_HALF_UP} round_mode_t, used for the round_en encoding in benches
- Sub-module cplx_round_sat (parameters P_W, OUT_W, FRAC_SHIFT): combinational round/shift/saturate for one component, returning value and overflow bit. It is instantiated twice in stage 4.

Test Plan (A_W=B_W=OUT_W=16, FRAC_SHIFT=15, PIPE_NUM=4, m_ready=1 unless stated):
1. Basic scaling: a=(16384+0j), b=(16384+0j), round_en=0 → z=(8192+0j), z_ovf=0; m_valid rises 3 edges after acceptance.
2. Conjugate mode: a=(1000+2000j), b=(16384+16384j), conj_b=1 → z=(1500+500j); same data with conj_b=0 → z=(−500+1500j).
3. Rounding: a=(1+0j), b=(16384+0j) → z_re=1 with round_en=1, z_re=0 with round_en=0. Also a=(−1+0j) → 0 with round_en=1, −1 with round_en=0.
4. Saturation: a=(−32768−32768j), b=(−32768+0j) → z=(32767+32767j), z_ovf=1; the next in-range sample gives z_ovf=0.
5. Backpressure: stream 10 samples with s_valid=1 and hold m_ready=0.
   - s_ready drops once 4 samples are held.
   - Toggle m_ready in a 1-0-1-1-0 pattern: all 10 results emerge in order, none lost or duplicated.
   - m_last is asserted only on sample 10.
6. Reset mid-stream: assert rst for 1 cycle with 3 samples in flight → m_valid=0 from the next cycle, none of the 3 ever appears, and the first post-reset sample has latency 4 exactly.
